// File: rtl/vga_pkg.sv
// Shared geometry, widths and fetch FSM encoding for the VGA/VRAM arbiter.
package vga_pkg;
  localparam int CELL_SHIFT = 3;
  localparam int H_CELLS    = 160;
  localparam int V_CELLS    = 128;
  localparam int V_ACTIVE   = 1024;
  localparam int ADDR_W     = 15;
  localparam int COLOR_W    = 12;
  localparam int PIX_W      = 12;
  localparam int COL_W      = $clog2(H_CELLS);
  localparam int NUM_CELLS  = H_CELLS * V_CELLS;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;

  // First cell address of a framebuffer row; shift-add for the 160-wide layout.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ADDR_W-1:0] row);
    if (H_CELLS == 160) return (row << 7) + (row << 5);
    else                return ADDR_W'(row * H_CELLS);
  endfunction
endpackage

// File: rtl/vga_line_buf.sv
// One-row line buffer: single write port, registered read port (1-cycle latency).
module vga_line_buf
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [COL_W-1:0]   waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [COL_W-1:0]   raddr,
  output logic [COLOR_W-1:0] rdata
);
  logic [COLOR_W-1:0] mem_q [H_CELLS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port VRAM between the per-line display prefetch and a CPU port.
// Define VRAM_CPU_READ_EN to enable CPU reads; otherwise every CPU request is a write.
module vga_vram_arbiter
  import vga_pkg::*;
(
  input  logic               pix_clk,
  input  logic               pix_rst_n,
  input  logic [PIX_W-1:0]   pix_x,
  input  logic [PIX_W-1:0]   pix_y,
  input  logic               pix_valid,
  input  logic               hsync,
  input  logic               vsync,
  output logic [COLOR_W-1:0] rgb,
  output logic               rgb_hsync,
  output logic               rgb_vsync,
  output logic               rgb_valid,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [COLOR_W-1:0] cpu_wdata,
  output logic               cpu_ack,
  output logic [COLOR_W-1:0] cpu_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);
  fetch_state_e       state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, fill_idx_q, fill_idx_d;
  logic [ADDR_W-1:0]  base_q, base_d, tgt_row;
  logic               fill_q, fill_d, ack_q, rdy_q;
  logic               pv_q, hs_q, vs_q;
  logic [PIX_W-1:0]   py_q;
  logic [PIX_W:0]     y_next;
  logic               trigger, grant, cpu_in_range, cpu_wr;
  logic [COLOR_W-1:0] lb_rdata;

  // Falling edge of pix_valid marks the end of line py_q.
  assign trigger      = pv_q & ~pix_valid;
  assign y_next       = {1'b0, py_q} + {{PIX_W{1'b0}}, 1'b1};
  assign tgt_row      = (py_q == PIX_W'(V_ACTIVE - 1)) ? '0 : ADDR_W'(y_next >> CELL_SHIFT);
  assign cpu_in_range = (cpu_addr < ADDR_W'(NUM_CELLS));
  // ack_q blocks a second grant from a request still held in the ack cycle.
  assign grant        = rdy_q & (state_q == IDLE) & ~trigger & cpu_req & ~ack_q;

`ifdef VRAM_CPU_READ_EN
  logic cpu_rd_q;
  assign cpu_wr    = cpu_we;
  assign cpu_rdata = cpu_rd_q ? mem_rdata : '0;
  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) cpu_rd_q <= 1'b0;
    else            cpu_rd_q <= grant & cpu_in_range & ~cpu_we;
  end
`else
  logic unused_cpu_we;
  assign unused_cpu_we = cpu_we;
  assign cpu_wr        = 1'b1;
  assign cpu_rdata     = '0;
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    base_d     = base_q;
    fill_d     = 1'b0;
    fill_idx_d = col_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = FETCH;
          col_d   = '0;
          base_d  = row_base(tgt_row);
        end else if (grant && cpu_in_range) begin
          mem_en    = 1'b1;
          mem_we    = cpu_wr;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wr ? cpu_wdata : '0;
        end
      end
      FETCH: begin
        mem_en   = 1'b1;
        mem_addr = base_q + ADDR_W'(col_q);
        fill_d   = 1'b1;
        col_d    = col_q + COL_W'(1);
        if (col_q == COL_W'(H_CELLS - 1)) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pix_clk or negedge pix_rst_n) begin
    if (!pix_rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      base_q     <= '0;
      fill_q     <= 1'b0;
      fill_idx_q <= '0;
      ack_q      <= 1'b0;
      rdy_q      <= 1'b0;
      pv_q       <= 1'b0;
      py_q       <= '0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      base_q     <= base_d;
      fill_q     <= fill_d;
      fill_idx_q <= fill_idx_d;
      ack_q      <= grant;
      rdy_q      <= 1'b1;
      pv_q       <= pix_valid;
      py_q       <= pix_y;
      hs_q       <= hsync;
      vs_q       <= vsync;
    end
  end

  vga_line_buf u_line_buf (
    .clk   (pix_clk),
    .we    (fill_q),
    .waddr (fill_idx_q),
    .wdata (mem_rdata),
    .raddr (COL_W'(pix_x >> CELL_SHIFT)),
    .rdata (lb_rdata)
  );

  assign cpu_ack   = ack_q;
  assign rgb_valid = pv_q;
  assign rgb_hsync = hs_q;
  assign rgb_vsync = vs_q;
  assign rgb       = pv_q ? lb_rdata : '0;
endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench: a line-level display/VRAM model checked every cycle plus literal pins.
module tb_vga_vram_arbiter;
  logic        clk, rst_n;
  logic [11:0] pix_x, pix_y;
  logic        pix_valid, hsync, vsync;
  logic [11:0] rgb;
  logic        rgb_hsync, rgb_vsync, rgb_valid;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [11:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, mem_en, mem_we;
  logic [14:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata;

  vga_vram_arbiter dut (
    .pix_clk(clk), .pix_rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .rgb_hsync(rgb_hsync), .rgb_vsync(rgb_vsync), .rgb_valid(rgb_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // VRAM environment: single port, 1-cycle read latency.
  logic [11:0] vram [32768];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else        mem_rdata <= vram[mem_addr];
    end
  end

  int errs = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [11:0] pat(input int i);
    return 12'(i * 37 + 5);
  endfunction

  // Model state: framebuffer as the CPU sees it, and the line snapshot due on screen.
  logic [11:0] fb [20480];
  logic [11:0] line_m [160];
  bit          line_ok = 0, cpu_busy = 0;
  int          fidx = -1, fbase = 0, first_fetch_addr = -1;
  logic        prev_pv = 0, prev_hs = 0, prev_vs = 0;
  logic [11:0] prev_x = 0, prev_y = 0;

  initial begin
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        chk("rst_outputs_zero", 32'(|{rgb, rgb_hsync, rgb_vsync, rgb_valid, cpu_ack,
                                      cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
        prev_pv = 0; prev_hs = 0; prev_vs = 0; prev_x = 0; prev_y = 0;
        fidx = -1; line_ok = 0;
      end else begin
        chk("rgb_valid", 32'(rgb_valid), 32'(prev_pv));
        chk("rgb_hsync", 32'(rgb_hsync), 32'(prev_hs));
        chk("rgb_vsync", 32'(rgb_vsync), 32'(prev_vs));
        if (!prev_pv)     chk("rgb_blank", 32'(rgb), 32'd0);
        else if (line_ok) chk("rgb_pix", 32'(rgb), 32'(line_m[prev_x / 8]));
        if (fidx >= 0) begin
          chk("fetch_beat", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 15'(fbase + fidx)}));
          if (fidx == 0) first_fetch_addr = int'(mem_addr);
          fidx = (fidx == 159) ? -1 : fidx + 1;
        end else if (!cpu_busy) begin
          chk("bus_idle", 32'(mem_en), 32'd0);
        end
        if (prev_pv && !pix_valid) begin
          int yy, row;
          yy = int'(prev_y);
          row = (yy == 1023) ? 0 : (yy + 1) / 8;
          fbase = row * 160;
          for (int c = 0; c < 160; c++) line_m[c] = fb[fbase + c];
          line_ok = 1;
          fidx = 0;
        end
        prev_pv = pix_valid; prev_hs = hsync; prev_vs = vsync;
        prev_x = pix_x; prev_y = pix_y;
      end
    end
  end

  task automatic cpu_op(input bit we, input int addr, input logic [11:0] wd,
                        input int want_lat, input logic [11:0] want_rd, input string nm);
    bit wr_eff, inr, got;
    int c0, lat;
    logic [11:0] rd, g_wd;
    logic g_en, g_we;
    logic [14:0] g_addr;
`ifdef VRAM_CPU_READ_EN
    wr_eff = we;
`else
    wr_eff = 1'b1;
`endif
    inr = addr < 20480;
    got = 0; lat = -1; rd = 0;
    g_en = 0; g_we = 0; g_addr = 0; g_wd = 0;
    @(negedge clk);
    cpu_req = 1; cpu_we = we; cpu_addr = 15'(addr); cpu_wdata = wd; cpu_busy = 1;
    c0 = cyc;
    for (int i = 0; i < 400 && !got; i++) begin
      #2;
      if (cpu_ack) begin
        got = 1; lat = cyc - c0; rd = cpu_rdata;
        chk({nm, "_nodup"}, 32'(mem_en), 32'd0);
      end else begin
        g_en = mem_en; g_we = mem_we; g_addr = mem_addr; g_wd = mem_wdata;
        @(negedge clk);
      end
    end
    if (!got) chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_latency"}, 32'(lat), 32'(want_lat));
      chk({nm, "_mem_en"}, 32'(g_en), 32'(inr));
      if (inr) begin
        chk({nm, "_mem_we"}, 32'(g_we), 32'(wr_eff));
        chk({nm, "_mem_addr"}, 32'(g_addr), 32'(addr));
        if (wr_eff) chk({nm, "_mem_wdata"}, 32'(g_wd), 32'(wd));
      end
      chk({nm, "_rdata"}, 32'(rd), (!wr_eff && inr) ? 32'(want_rd) : 32'd0);
      if (inr && wr_eff) fb[addr] = wd;
    end
    @(negedge clk);
    cpu_req = 0; cpu_busy = 0;
  endtask

  logic [11:0] pins [8];

  task automatic run_blank(input int y, input bit rst_mid);
    for (int j = 0; j < 170; j++) begin
      @(negedge clk);
      pix_valid = 0; pix_x = 0;
      hsync = !(j >= 10 && j < 40);
      vsync = !(y == 1023 && j < 50);
      if (rst_mid && j == 50) begin
        rst_n = 0;
        #2 chk("rst_async_mem_en", 32'({mem_en, mem_addr}), 32'd0);
        chk("rst_async_rgb", 32'({rgb, rgb_valid, rgb_hsync}), 32'd0);
      end
      if (rst_mid && j == 54) rst_n = 1;
    end
  endtask

  // mode 0: plain line; 1: CPU write raised at the trigger cycle; 2: reset mid-fetch.
  task automatic run_line(input int y, input int mode);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      pix_valid = 1; pix_x = 12'(i * 8 + i % 8); pix_y = 12'(y);
      hsync = 1; vsync = 1;
      #2;
      if (i < 8) pins[i] = rgb;
    end
    if (mode == 1) begin
      fork
        run_blank(y, 1'b0);
        cpu_op(1'b1, 323, 12'h5A5, 163, 12'h000, "stall_wr");
      join
    end else begin
      run_blank(y, mode == 2);
    end
  endtask

  initial begin
    rst_n = 0; pix_x = 0; pix_y = 0; pix_valid = 0; hsync = 0; vsync = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0;
    for (int i = 0; i < 32768; i++) vram[i] = (i < 20480) ? pat(i) : 12'h000;
    for (int i = 0; i < 20480; i++) fb[i] = pat(i);
    repeat (3) @(negedge clk);
    #2;
    chk("reset_rgb", 32'(rgb), 32'd0);
    chk("reset_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);

    cpu_op(1'b1, 0, 12'hF00, 1, 12'h000, "wr0");
    cpu_op(1'b1, 161, 12'h0AB, 1, 12'h000, "wr161");
    cpu_op(1'b1, 20480, 12'h777, 1, 12'h000, "wr_oor");
`ifdef VRAM_CPU_READ_EN
    cpu_op(1'b0, 20480, 12'h000, 1, 12'h000, "rd_oor");
    cpu_op(1'b0, 161, 12'h000, 1, 12'h0AB, "rd161");
    cpu_op(1'b0, 0, 12'h000, 1, 12'hF00, "rd0");
    cpu_op(1'b0, 1, 12'h000, 1, 12'h02A, "rd1");
`else
    cpu_op(1'b0, 300, 12'h123, 1, 12'h000, "we_ignored");
`endif

    run_line(1023, 0);
    chk("base_after_1023", 32'(first_fetch_addr), 32'd0);
    for (int y = 0; y < 8; y++) begin
      run_line(y, 0);
      if (y == 0) chk("px_cell0_f00", 32'(pins[1]), 32'h0F00);
    end
    chk("base_after_7", 32'(first_fetch_addr), 32'd160);
    run_line(8, 0);
    chk("px_row1_cell1_0ab", 32'(pins[2]), 32'h00AB);
    run_line(15, 1);
    chk("base_after_15", 32'(first_fetch_addr), 32'd320);
    run_line(16, 2);
    chk("px_row2_cell3_old", 32'(pins[4]), 32'h0EB4);
    cpu_op(1'b1, 5, 12'h0F0, 1, 12'h000, "post_rst_wr");
    run_line(20, 0);
    run_line(21, 0);
    chk("px_row2_cell3_new", 32'(pins[4]), 32'h05A5);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Shares one single-port, synchronous video RAM between the VGA display path and a CPU-side read/write port. It sits directly behind the VGA timing generator and consumes its `pix_x`, `pix_y`, `pix_valid`, `hsync` and `vsync`. During each horizontal blank it prefetches the next 160-cell row of a 160×128 framebuffer (one 12-bit RGB word per 8×8 pixel cell) into an internal line buffer. It grants the RAM to CPU requests in every other cycle and drives delayed, pixel-aligned RGB and sync signals to the monitor.

## Interface
- `CELL_SHIFT`, 3, log2 of cell edge in pixels
- `H_CELLS`, 160, cells per row
- `V_CELLS`, 128, cell rows
- `ADDR_W`, 15, VRAM word address width
- `COLOR_W`, 12, RGB word width
- `V_ACTIVE`, 1024, active lines per frame
- `pix_clk`  in  1  pixel clock; all logic on rising edge
- `pix_rst_n`  in  1  asynchronous, active-low reset
- `pix_x`, `pix_y`  in  12 each  active-area position from the timing generator
- `pix_valid`, `hsync`, `vsync`  in  1 each  timing-generator outputs
- `rgb`  out  COLOR_W  pixel colour, aligned with `rgb_hsync`/`rgb_vsync`
- `rgb_hsync`, `rgb_vsync`, `rgb_valid`  out  1 each  inputs delayed 1 cycle
- `cpu_req`  in  1  request, held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  cell address, row*H_CELLS + col
- `cpu_wdata`  in  COLOR_W  write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  COLOR_W  read data, valid with `cpu_ack`
- `mem_en`, `mem_we`  out  1 each  VRAM strobes
- `mem_addr`  out  ADDR_W  VRAM address
- `mem_wdata`  out  COLOR_W  VRAM write data
- `mem_rdata`  in  COLOR_W  VRAM read data, 1 cycle after `mem_en`

## Operation
- Fetch trigger: a registered copy `pv_d` of `pix_valid` is kept. The trigger fires on the falling edge, `pv_d`=1 and `pix_valid`=0. The line just finished, `y`, is captured from `pix_y` registered one cycle earlier.
- Target row: `((y+1) >> CELL_SHIFT)`. When `y == V_ACTIVE-1`, the target row is 0 (prefetch for the next frame).
- FSM states:
  - `IDLE`: on trigger, go to `FETCH` with `col=0` and `base=row*H_CELLS`. `row*H_CELLS` is computed as `(row<<7)+(row<<5)` for the default geometry and generically otherwise.
  - `FETCH`: issue a read at `base+col` each cycle and increment `col`. After issuing `col=H_CELLS-1`, go to `DRAIN`.
  - `DRAIN`: accept the final return word, then go to `IDLE`.
- Returned words are written to line-buffer entry `col` one cycle after issue, using a registered issue flag and index.
- Arbitration:
  - The display fetch always wins.
  - A CPU request is granted only in `IDLE` with no trigger that cycle.
  - A trigger arriving while a CPU read is returning does not stall; the returning data is steered by its tag.
- CPU write: `mem_en`=`mem_we`=1 in the grant cycle; `cpu_ack` pulses in the next cycle.
- CPU read: `mem_en`=1 in the grant cycle. `cpu_ack` and `cpu_rdata` (= `mem_rdata`) appear in the next cycle.
- Out-of-range CPU address (`>= H_CELLS*V_CELLS`): no memory access. `cpu_ack` pulses 1 cycle after the grant and `cpu_rdata`=0.
- A new grant requires `cpu_req` to be sampled high again in the cycle after `cpu_ack`. There are no back-to-back duplicates from a held request.
- Display output: line buffer read at `pix_x >> CELL_SHIFT`. `rgb` = buffer data when `rgb_valid`, otherwise 0.

## Timing
- Reset values: `rgb`=0; `rgb_hsync`, `rgb_vsync`, `rgb_valid`=0; `cpu_ack`=0; `cpu_rdata`=0; `mem_en`, `mem_we`=0; `mem_addr`, `mem_wdata`=0; FSM=`IDLE`; line buffer contents undefined.
- Fetch sequence, trigger at cycle T: reads issue at T+1…T+160, words land at T+2…T+161, FSM returns to `IDLE` at T+162. This is 162 cycles, well within the 408-cycle horizontal blank.
- Display latency: exactly 1 cycle from inputs to `rgb` and the delayed syncs.
- Reset asserted mid-fetch: the fetch aborts. There is no trigger on release until the next falling edge of `pix_valid`, and the line shown until then is undefined.
- CPU worst-case wait: 163 cycles.

## Configuration
- `VRAM_CPU_READ_EN` defined: CPU reads work as described above.
- Without it:
  - `cpu_we` is ignored and every request is a write.
  - `cpu_rdata` is tied to 0.
  - The read-return steering logic is removed.

## Structure
- Package `vga_pkg`: geometry constants (`CELL_SHIFT`, `H_CELLS`, `V_CELLS`, `V_ACTIVE`), widths, and the FSM state enum `IDLE`/`FETCH`/`DRAIN`.
- Sub-module `vga_line_buf`: `H_CELLS`×`COLOR_W` simple dual-port RAM with one write port, one registered read port, and 1-cycle read latency.

## Test plan
- CPU write addr 0 = 12'hF00, run one frame -> pixels (0..7, 0..7) show `rgb`=12'hF00 one cycle after `pix_valid`.
- `cpu_req` asserted at trigger cycle T -> no `cpu_ack` before T+163; `mem_addr` sequence is `base`..`base+159` contiguous.
- CPU write to addr 20480 -> no `mem_en`; `cpu_ack` next cycle; a read of the same address returns 0.
- End of line `y`=1023 -> fetch `base`=0; `y`=7 -> `base`=160.
- Deassert `pix_rst_n` at T+50 of a fetch -> all outputs zero asynchronously; FSM is `IDLE` after release.
- CPU read addr 161 after writing 12'h0AB -> `cpu_ack` and `cpu_rdata`=12'h0AB one cycle after grant (with `VRAM_CPU_READ_EN`).
